// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states,
// and the alignment rule.
package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Reserved size is always an error; halves need even and words need 4-byte alignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_resp_mem_lane.sv
// Byte/half/word lane steering for stores and lane selection plus extension for loads.
module mem_lane
  import data_mem_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]         size,
  input  logic               uns,
  input  logic [1:0]         addr_lo,
  input  logic [WIDTH-1:0]   rword,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH/8-1:0] be,
  output logic [WIDTH-1:0]   wword,
  output logic [WIDTH-1:0]   rdata
);

  localparam int unsigned LANES = WIDTH / 8;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be       = '0;
    wword    = wdata;
    rdata    = '0;
    byte_sel = rword[{addr_lo, 3'b000} +: 8];
    half_sel = rword[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_B: begin
        be    = LANES'(1) << addr_lo;
        wword = {LANES{wdata[7:0]}};
        rdata = {{(WIDTH-8){~uns & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be    = LANES'(3) << {addr_lo[1], 1'b0};
        wword = {(LANES/2){wdata[15:0]}};
        rdata = {{(WIDTH-16){~uns & half_sel[15]}}, half_sel};
      end
      SZ_W: begin
        be    = '1;
        wword = wdata;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Multi-cycle data-memory responder: one request at a time, fixed latency,
// registered response held until the requester takes it.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = WIDTH / 8;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    commit;
  logic                    accept;

  logic                    we_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]        wdata_q;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [ADDR_WIDTH-3:0]   idx;
  logic [WIDTH-1:0]        rword;
  logic [LANES-1:0]        be;
  logic [WIDTH-1:0]        wword;
  logic [WIDTH-1:0]        ld_data;
  logic                    err_c;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign idx       = addr_q[ADDR_WIDTH-1:2];
  assign rword     = mem[idx];
  assign err_c     = misaligned(size_q, addr_q[1:0]);

  mem_lane #(.WIDTH(WIDTH)) u_lane (
    .size    (size_q),
    .uns     (uns_q),
    .addr_lo (addr_q[1:0]),
    .rword   (rword),
    .wdata   (wdata_q),
    .be      (be),
    .wword   (wword),
    .rdata   (ld_data)
  );

  // Next-state: count down the latency in WAIT, commit on the final edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_valid <= (state_d == RESP);
      if (commit) begin
        rsp_err   <= err_c;
        rsp_rdata <= (err_c || we_q) ? '0 : ld_data;
      end
    end
  end

  // Request capture; later req_* activity is ignored until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage is never cleared; a reset on the commit edge drops the pending store.
  always_ff @(posedge clk) begin
    if (commit && !rst && we_q && !err_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wword[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized bench for data_mem_resp against a byte-addressed reference model,
// across four instances with latencies 2, 4, 1 and 15.
module tb_data_mem_resp;
  import data_mem_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 17;
  localparam int         ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic [1:0]    sel;

  logic          rv_v [ND];
  logic          rr_v [ND];
  logic          rdy_v[ND];
  logic          vld_v[ND];
  logic          err_v[ND];
  logic [W-1:0]  rd_v [ND];

  logic          req_ready, rsp_valid, rsp_err;
  logic [W-1:0]  rsp_rdata;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    assign rv_v[g] = req_valid && (sel == 2'(g));
    assign rr_v[g] = rsp_ready && (sel == 2'(g));
    data_mem_resp #(
      .WIDTH      (W),
      .ADDR_WIDTH (AW),
      .LATENCY    (g == 0 ? 2 : g == 1 ? 4 : g == 2 ? 1 : 15)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (rv_v[g]),
      .req_ready    (rdy_v[g]),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (vld_v[g]),
      .rsp_ready    (rr_v[g]),
      .rsp_rdata    (rd_v[g]),
      .rsp_err      (err_v[g])
    );
  end

  always_comb begin
    req_ready = rdy_v[sel];
    rsp_valid = vld_v[sel];
    rsp_err   = err_v[sel];
    rsp_rdata = rd_v[sel];
  end

  function automatic int lat_of(input logic [1:0] k);
    case (k)
      2'd0:    return 2;
      2'd1:    return 4;
      2'd2:    return 1;
      default: return 15;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (dut %0d, cycle %0d)", tag, got, exp, sel, cyc);
    end
  endtask

  // Reference model: one byte per address, little-endian, per instance.
  bit [7:0] bm [int];

  function automatic int bkey(input logic [1:0] k, input logic [AW-1:0] a);
    return int'(k) * (1 << AW) + int'(a);
  endfunction

  function automatic bit m_err(input logic [1:0] s, input logic [AW-1:0] a);
    int n;
    if (s == 2'b11) return 1'b1;
    n = 1 << s;
    return (int'(a) % n) != 0;
  endfunction

  function automatic bit m_have(input logic [1:0] k, input logic [1:0] s, input logic [AW-1:0] a);
    for (int i = 0; i < (1 << s); i++)
      if (!bm.exists(bkey(k, a + AW'(i)))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] k, input logic [1:0] s,
                                         input bit uns, input logic [AW-1:0] a);
    int     n = 1 << s;
    longint v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(bm[bkey(k, a + AW'(i))]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic m_store(input logic [1:0] k, input logic [1:0] s,
                         input logic [AW-1:0] a, input logic [31:0] wd);
    for (int i = 0; i < (1 << s); i++)
      bm[bkey(k, a + AW'(i))] = wd[8*i +: 8];
  endtask

  // One full transaction on the selected instance with dly cycles of response backpressure.
  task automatic do_txn(input bit we, input logic [1:0] s, input bit uns, input logic [AW-1:0] a,
                        input logic [31:0] wd, input int dly, output logic [31:0] got);
    int          n;
    bit          e;
    logic [31:0] exp;
    e   = m_err(s, a);
    exp = (e || we) ? 32'h0 : m_load(sel, s, uns, a);
    req_we = we; req_size = s; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      got = 'x;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = AW'($urandom); req_wdata = $urandom;
    if (we && !e) m_store(sel, s, a, wd);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 40);
    chk("latency", 32'(n), 32'(lat_of(sel)));
    chk("rsp_err", 32'(rsp_err), 32'(e));
    chk("rsp_rdata", rsp_rdata, exp);
    got = rsp_rdata;
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp);
      chk("hold_err", 32'(rsp_err), 32'(e));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_req_ready", 32'(req_ready), 32'd1);
  endtask

  // req_valid and rsp_ready held high: accepts must be LATENCY+2 apart.
  task automatic b2b(input int naccept);
    int          l = lat_of(sel);
    int          last_acc = -1;
    int          pending = -1;
    int          got = 0;
    int          guard = 0;
    bit          a;
    logic [31:0] wd = $urandom;
    req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0; req_addr = AW'(32'h40); req_wdata = wd;
    m_store(sel, SZ_W, AW'(32'h40), wd);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    while ((got < naccept || pending >= 0) && guard < 2000) begin
      a = req_ready;
      @(posedge clk); #1;
      guard++;
      if (a) begin
        if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'(l + 2));
        last_acc = cyc;
        pending  = cyc;
        got++;
        if (got >= naccept) req_valid = 1'b0;
      end
      if (rsp_valid && pending >= 0 && cyc != pending) begin
        chk("b2b_latency", 32'(cyc - pending), 32'(l));
        chk("b2b_rdata", rsp_rdata, 32'h0);
        pending = -1;
      end
    end
    if (guard >= 2000) chk("b2b_timeout", 32'(got), 32'(naccept));
    req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("b2b_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0]   got;
    logic [1:0]    s;
    logic [AW-1:0] a;
    bit            we, uns;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      sel = 2'(k); #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    end
    sel = 2'd0;
    rst = 1'b0; #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed sequence on the LATENCY=2 instance.
    do_txn(1'b1, SZ_W, 1'b0, AW'(32'h10), 32'hDEADBEEF, 0, got);
    do_txn(1'b0, SZ_W, 1'b0, AW'(32'h10), 32'h0, 0, got);
    chk("word_load", got, 32'hDEADBEEF);
    do_txn(1'b1, SZ_B, 1'b0, AW'(32'h11), 32'h000000AA, 1, got);
    do_txn(1'b0, SZ_W, 1'b0, AW'(32'h10), 32'h0, 0, got);
    chk("merged_word", got, 32'hDEADAAEF);
    do_txn(1'b0, SZ_B, 1'b0, AW'(32'h11), 32'h0, 0, got);
    chk("byte_signed", got, 32'hFFFFFFAA);
    do_txn(1'b0, SZ_B, 1'b1, AW'(32'h11), 32'h0, 0, got);
    chk("byte_unsigned", got, 32'h000000AA);
    do_txn(1'b0, SZ_H, 1'b0, AW'(32'h12), 32'h0, 0, got);
    chk("half_signed", got, 32'hFFFFDEAD);
    do_txn(1'b1, SZ_W, 1'b0, AW'(32'h12), 32'h12345678, 0, got);
    do_txn(1'b0, SZ_W, 1'b0, AW'(32'h10), 32'h0, 0, got);
    chk("no_write_on_err", got, 32'hDEADAAEF);
    do_txn(1'b0, SZ_R, 1'b0, AW'(32'h10), 32'h0, 0, got);
    do_txn(1'b0, SZ_W, 1'b1, AW'(32'h10), 32'h0, 5, got);

    // Reset while a store is waiting on the LATENCY=4 instance.
    sel = 2'd1;
    do_txn(1'b1, SZ_W, 1'b0, AW'(32'h20), 32'hCAFEF00D, 0, got);
    do_txn(1'b0, SZ_W, 1'b0, AW'(32'h20), 32'h0, 0, got);
    req_we = 1'b1; req_size = SZ_W; req_addr = AW'(32'h20); req_wdata = 32'h11111111;
    req_valid = 1'b1;
    chk("mid_wait_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1; #1;
    chk("rst_blocks_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_err", 32'(rsp_err), 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0; #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    do_txn(1'b0, SZ_W, 1'b0, AW'(32'h20), 32'h0, 0, got);
    chk("store_discarded", got, 32'hCAFEF00D);

    // Latency sweep with back-to-back requests.
    sel = 2'd2; b2b(5);
    sel = 2'd3; b2b(3);

    // Randomized traffic across all instances.
    repeat (120) begin
      sel = 2'($urandom_range(0, 3));
      we  = 1'($urandom);
      s   = 2'($urandom_range(0, 3));
      uns = 1'($urandom);
      a   = AW'(32'h80 + $urandom_range(0, 31));
      if (!we && !m_err(s, a) && !m_have(sel, s, a)) begin
        we = 1'b1; s = SZ_W; a = a & ~AW'(3);
      end
      do_txn(we, s, uns, a, $urandom, int'($urandom_range(0, 3)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Memory-side responder for the core's data-load/store port, with a configurable multi-cycle latency.
- Accepts one request at a time over a valid/ready request channel and returns the result over a valid/ready response channel.
- Owns the data storage array, performs byte/half/word lane steering and load extension, and flags misaligned accesses.
- Replaces the core's combinational data memory once the pipeline gains a stall-capable memory stage.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 17, byte-address width; storage depth is 2**(ADDR_WIDTH-2) words.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  WIDTH  store data, right-aligned in bits [7:0], [15:0] or [31:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access or reserved size.

Behaviour:
- FSM states IDLE, WAIT, RESP.
- Reset (rst high at an edge): state IDLE, cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. req_ready is 0 while rst is high. Storage is not cleared.
- req_ready = (state==IDLE) && !rst, driven combinationally.
- Accept at edge t when req_valid && req_ready: latch we/size/unsigned/addr/wdata, cnt <= LATENCY-1, state -> WAIT.
- WAIT: if cnt!=0, cnt decrements. If cnt==0, at that edge (edge t+LATENCY) state -> RESP, the access commits, and rsp_rdata/rsp_err are registered.
- rsp_valid is high in the cycle after edge t+LATENCY.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready at an edge, then state -> IDLE and rsp_valid 0.
- Minimum spacing between accepts is LATENCY+2 edges. A request presented in RESP is not accepted until IDLE.
- Error conditions: size 11; half with addr[0]=1; word with addr[1:0]!=0. On error: rsp_err=1, rsp_rdata=0, no storage write.
- Store lanes: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes addr[1]*2 and +1 with wdata[15:0]; word writes all four lanes. Unselected lanes are unchanged.
- Load extension: word returns the word. Half selects word[addr[1]*16 +: 16]. Byte selects word[addr[1:0]*8 +: 8]. Both then sign- or zero-extend per latched req_unsigned.
- Word index is addr[ADDR_WIDTH-1:2]. The index cannot go out of range by construction.
- Reset mid-operation:
  - In WAIT, the pending store is discarded (no write).
  - In RESP, the store has already committed and stays; the response is dropped.
- Input changes on req_* after acceptance have no effect.

Decomposition:
- Package data_mem_pkg holds:
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - state enum {IDLE, WAIT, RESP} as logic [1:0];
  - a function computing misalignment from size and addr[1:0].
- One combinational sub-module, mem_lane: inputs size, unsigned, addr[1:0], stored word, wdata. Outputs the 4-bit byte-enable, the lane-aligned write word, and the extended load data.
- data_mem_resp holds the FSM, counter, storage array and response registers.

Test Plan:
- Word store/load, LATENCY=2: store 0xDEADBEEF at 0x10 (accept at edge t) -> rsp_valid high after edge t+2, rsp_err 0, rsp_rdata 0. Then word load at 0x10 -> 0xDEADBEEF.
- Byte store then loads: store byte 0xAA at 0x11.
  - Word load at 0x10 -> 0xDEADAAEF.
  - Signed byte load at 0x11 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
  - Signed half load at 0x12 -> 0xFFFFDEAD.
- Misaligned/reserved:
  - Word store 0x12345678 at 0x12 -> rsp_err 1, rsp_rdata 0; word load at 0x10 still 0xDEADAAEF.
  - size 11 load -> rsp_err 1.
- Backpressure: hold rsp_ready 0 for 5 cycles during a load response -> rsp_valid, rsp_rdata and rsp_err stable, req_ready 0. Raise rsp_ready -> IDLE next cycle, req_ready 1.
- Reset mid-WAIT: LATENCY=4, store 0x11111111 at 0x20, assert rst one cycle after accept -> outputs return to reset values; later word load at 0x20 returns the prior contents.
- Latency sweep LATENCY=1 and 15 with back-to-back req_valid held high -> accepts spaced exactly LATENCY+2 edges, each rsp_valid exactly LATENCY edges after its accept.
